map_write_scheduler: RTL
========================

// Module: map_write_scheduler
// PURPOSE
// - Sequences all sprite moves into the single map RAM write port: erase old tile, write sprite at new tile.
// - Arbitrates pacman (req 0) and ghosts (req 1..NUM_GHOSTS) round-robin; one move in flight at a time.
// - Remembers the tile under each ghost (dot/pill) and restores it when the ghost leaves.
// PARAMETERS
// - NUM_GHOSTS  2   ghost requesters; NUM_REQ = NUM_GHOSTS+1
// - MAP_W       40  tiles per map row; addr = y*MAP_W + x
// - ADDR_W      11  map RAM address width
// PORTS
// - CLOCK_50  in   1           system clock; all logic on posedge
// - reset     in   1           synchronous, active-low reset
// - req       in   NUM_REQ     move request, held high until matching done
// - curr_x    in   NUM_REQ*6   per-requester current x (packed, req0 in LSBs)
// - curr_y    in   NUM_REQ*5   per-requester current y
// - next_x    in   NUM_REQ*6   per-requester target x
// - next_y    in   NUM_REQ*5   per-requester target y
// - done      out  NUM_REQ     one-cycle pulse: move for that requester fully written
// - rdaddr    out  ADDR_W      map RAM read address (1-cycle read latency)
// - rddata    in   4           map RAM read data (tile_t)
// - wren      out  1           map RAM write enable
// - wraddr    out  ADDR_W      map RAM write address
// - wrdata    out  4           map RAM write data (tile_t)
// BEHAVIOUR
// - Reset (reset==0 at posedge): state IDLE, done=0, wren=0, wraddr=0, wrdata=0, rdaddr=0,
//   RR pointer=0, all saved-under tiles=EMPTY. Reset mid-move aborts it; no further write issued.
// - FSM IDLE->RD->ERASE->WRITE->ACK->IDLE. Cycle n: IDLE, any req high -> latch grant g, coords.
//   n+1 RD: rdaddr=addr(next_g). n+2 ERASE: capture rddata; wren=1, wraddr=addr(curr_g),
//   wrdata=PACMAN?EMPTY:saved[g]. n+3 WRITE: wren=1, wraddr=addr(next_g), wrdata=PACMAN/GHOST.
//   n+4 ACK: done[g]=1, ghost saved[g] <- captured tile. Latency req->done = 4 cycles.
// - curr==next: IDLE->WRITE->ACK (done at n+2); no read, no erase, saved[g] unchanged.
// - Captured tile that is PACMAN or GHOST saved as EMPTY; WALL never expected (mover filters).
// - Arbitration: rr_arbiter, priority starts at pointer; pointer <- g+1 (mod NUM_REQ) on grant.
//   Simultaneous reqs: lowest index at/after pointer wins; others wait, no req ever starved.
// - Coords latched at grant; input changes or req drop mid-move ignored, move completes.
// - req still high in ACK cycle is not re-granted until IDLE (no back-to-back same-requester move
//   without a fresh IDLE evaluation). wren high only in ERASE/WRITE; done one-hot or zero.
// - Address arithmetic: y*MAP_W+x computed at ADDR_W bits, no wrap check (coords in range by design).
// CONFIGURATION
// - SCORE_EVT_EN defined: extra outputs dot_eaten, pill_eaten (1 bit each) pulse in WRITE cycle when
//   g==0 and captured tile is DOT / PILL; reset 0. Not defined: ports absent, no behaviour change.
// STRUCTURE
// - map_pkg: tile_t enum (EMPTY=0, WALL=1, DOT=2, PILL=3, PACMAN=4, GHOST=5), MAP_W, ADDR_W,
//   function map_addr(x,y). Shared with RAM writer, collision detect, VGA reader.
// - Sub-module rr_arbiter (NUM_REQ-wide req/pointer in, one-hot grant + index out, combinational).
// TESTING
// - Reset held 3 cycles, req=3'b111 -> wren=0, done=0 throughout; first grant after release is req0.
// - Pacman (20,20)->(21,20), rddata=DOT -> ERASE wraddr=820 data EMPTY, WRITE wraddr=821 data PACMAN,
//   done[0] at n+4; with SCORE_EVT_EN dot_eaten pulses once.
// - Ghost1 (16,13)->(17,13) over PILL, then (17,13)->(18,13) -> second ERASE wraddr=537 data PILL.
// - req=3'b111 held -> grant order 0,1,2,0; each done exactly 4 cycles after its IDLE grant.
// - Ghost2 curr==next=(23,13) -> single write wraddr=543 data GHOST, done[2] at n+2, no read.
// - reset low during WRITE -> wren=0 next cycle, no done; saved tiles EMPTY after release.

Source files
------------

// File: rtl/map_pkg.sv
// Shared map definitions: tile encoding, map geometry and tile addressing.
// Used by the write scheduler, RAM writer, collision detect and VGA reader.
package map_pkg;

  localparam int unsigned MAP_W  = 40;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned X_W    = 6;
  localparam int unsigned Y_W    = 5;
  localparam int unsigned TILE_W = 4;

  typedef enum logic [TILE_W-1:0] {
    EMPTY  = 4'd0,
    WALL   = 4'd1,
    DOT    = 4'd2,
    PILL   = 4'd3,
    PACMAN = 4'd4,
    GHOST  = 4'd5
  } tile_t;

  function automatic logic [ADDR_W-1:0] map_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(MAP_W) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/map_write_scheduler_if.sv
// Move-request and map-RAM port bundle of the map write scheduler.
// SCORE_EVT_EN adds the dot_eaten / pill_eaten score pulses.
interface map_write_scheduler_if #(
  parameter int unsigned NUM_GHOSTS = 2
);
  import map_pkg::*;

  localparam int unsigned NUM_REQ = NUM_GHOSTS + 1;

  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ*X_W-1:0] curr_x;
  logic [NUM_REQ*Y_W-1:0] curr_y;
  logic [NUM_REQ*X_W-1:0] next_x;
  logic [NUM_REQ*Y_W-1:0] next_y;
  logic [NUM_REQ-1:0]     done;
  logic [ADDR_W-1:0]      rdaddr;
  tile_t                  rddata;
  logic                   wren;
  logic [ADDR_W-1:0]      wraddr;
  tile_t                  wrdata;
`ifdef SCORE_EVT_EN
  logic                   dot_eaten;
  logic                   pill_eaten;
`endif

  // Scheduler side
  modport master (
    input  req, curr_x, curr_y, next_x, next_y, rddata,
    output done, rdaddr, wren, wraddr, wrdata
`ifdef SCORE_EVT_EN
    , output dot_eaten, pill_eaten
`endif
  );

  // Requester / map RAM side
  modport slave (
    output req, curr_x, curr_y, next_x, next_y, rddata,
    input  done, rdaddr, wren, wraddr, wrdata
`ifdef SCORE_EVT_EN
    , input dot_eaten, pill_eaten
`endif
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the lowest requesting index at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester overwrites the result
  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    for (int unsigned off = NUM_REQ; off > 0; off--) begin
      cand = IDX_W'((32'(ptr) + off - 1) % NUM_REQ);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/map_write_scheduler.sv
// Map write scheduler: serialises sprite moves (erase old tile, draw new tile) onto the single
// map RAM write port, restoring the tile each ghost covered. SCORE_EVT_EN adds score pulses.
module map_write_scheduler
  import map_pkg::*;
#(
  parameter int unsigned NUM_GHOSTS = 2
) (
  input logic             CLOCK_50,
  input logic             reset,
  map_write_scheduler_if.master bus
);

  localparam int unsigned NUM_REQ = NUM_GHOSTS + 1;
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {IDLE, RD, ERASE, WRITE, ACK} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, g_q, g_d;
  logic [ADDR_W-1:0]  curr_addr_q, curr_addr_d, next_addr_q, next_addr_d;
  logic               moved_q, moved_d;
  tile_t              cap_q, cap_d;
  tile_t              saved_q [NUM_REQ];
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               wren_q, wren_d;
  logic [ADDR_W-1:0]  rdaddr_q, rdaddr_d, wraddr_q, wraddr_d;
  tile_t              wrdata_q, wrdata_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic [X_W-1:0]     g_cx, g_nx;
  logic [Y_W-1:0]     g_cy, g_ny;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req   (bus.req),
    .ptr   (ptr_q),
    .grant (gnt),
    .idx   (gnt_idx)
  );

  assign g_cx = bus.curr_x[gnt_idx*X_W +: X_W];
  assign g_cy = bus.curr_y[gnt_idx*Y_W +: Y_W];
  assign g_nx = bus.next_x[gnt_idx*X_W +: X_W];
  assign g_ny = bus.next_y[gnt_idx*Y_W +: Y_W];

  function automatic tile_t sprite(input logic [IDX_W-1:0] g);
    return (g == '0) ? PACMAN : GHOST;
  endfunction

  // Next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    curr_addr_d = curr_addr_q;
    next_addr_d = next_addr_q;
    moved_d     = moved_q;
    cap_d       = cap_q;
    done_d      = '0;
    wren_d      = 1'b0;
    rdaddr_d    = rdaddr_q;
    wraddr_d    = wraddr_q;
    wrdata_d    = wrdata_q;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          g_d         = gnt_idx;
          ptr_d       = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
          curr_addr_d = map_addr(g_cx, g_cy);
          next_addr_d = map_addr(g_nx, g_ny);
          moved_d     = !((g_cx == g_nx) && (g_cy == g_ny));
          if (moved_d) begin
            state_d  = RD;
            rdaddr_d = map_addr(g_nx, g_ny);
          end else begin
            // Sprite stays put: redraw only, the tile underneath is left untouched
            state_d  = WRITE;
            wren_d   = 1'b1;
            wraddr_d = map_addr(g_nx, g_ny);
            wrdata_d = sprite(gnt_idx);
          end
        end
      end
      RD: begin
        state_d  = ERASE;
        wren_d   = 1'b1;
        wraddr_d = curr_addr_q;
        wrdata_d = (g_q == '0) ? EMPTY : saved_q[g_q];
      end
      ERASE: begin
        state_d  = WRITE;
        cap_d    = (bus.rddata == PACMAN || bus.rddata == GHOST) ? EMPTY : bus.rddata;
        wren_d   = 1'b1;
        wraddr_d = next_addr_q;
        wrdata_d = sprite(g_q);
      end
      WRITE: begin
        state_d     = ACK;
        done_d[g_q] = 1'b1;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      g_q         <= '0;
      curr_addr_q <= '0;
      next_addr_q <= '0;
      moved_q     <= 1'b0;
      cap_q       <= EMPTY;
      done_q      <= '0;
      wren_q      <= 1'b0;
      rdaddr_q    <= '0;
      wraddr_q    <= '0;
      wrdata_q    <= EMPTY;
      for (int i = 0; i < int'(NUM_REQ); i++) saved_q[i] <= EMPTY;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      g_q         <= g_d;
      curr_addr_q <= curr_addr_d;
      next_addr_q <= next_addr_d;
      moved_q     <= moved_d;
      cap_q       <= cap_d;
      done_q      <= done_d;
      wren_q      <= wren_d;
      rdaddr_q    <= rdaddr_d;
      wraddr_q    <= wraddr_d;
      wrdata_q    <= wrdata_d;
      if (state_q == ACK && moved_q && g_q != '0) saved_q[g_q] <= cap_q;
    end
  end

  assign bus.done   = done_q;
  assign bus.wren   = wren_q;
  assign bus.rdaddr = rdaddr_q;
  assign bus.wraddr = wraddr_q;
  assign bus.wrdata = wrdata_q;

`ifdef SCORE_EVT_EN
  logic dot_q, pill_q;

  // Pacman landing on a dot or pill, flagged in the WRITE cycle
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      dot_q  <= 1'b0;
      pill_q <= 1'b0;
    end else begin
      dot_q  <= (state_q == ERASE) && (g_q == '0) && (bus.rddata == DOT);
      pill_q <= (state_q == ERASE) && (g_q == '0) && (bus.rddata == PILL);
    end
  end

  assign bus.dot_eaten  = dot_q;
  assign bus.pill_eaten = pill_q;
`endif

endmodule
